score_display_n: RTL and testbench
==================================

// Module: score_display_n
// PURPOSE
//  Parametrised N-digit decimal score renderer for the 640x480 VGA path.
//  Converts a binary score to BCD with an iterative double-dabble FSM once per frame.
//  Draws the digits from an 8x8 glyph ROM, with integer pixel scaling and optional leading-zero blanking.
//  Output is one pixel-enable bit, ORed into the colour mux alongside the other sprite/draw blocks.
// PARAMETERS
//  XLOC        40  left pixel column of the most-significant digit
//  YLOC        40  top pixel row of the digit cells (must be >= 1)
//  DIGITS      3   number of decimal digits displayed (1..5)
//  SCORE_W     8   width of the binary score input (1..16)
//  SCALE_LOG2  0   glyph magnification = 2**SCALE_LOG2 (0..2); cell = 8<<SCALE_LOG2 px square
// PORTS
//  clk         in   1        100 MHz system clock
//  rst_n       in   1        asynchronous active-low reset
//  pixpulse    in   1        1-clk strobe every 4 clks (25 MHz pixel rate)
//  hcount      in   10       current x (0=left .. 639)
//  vcount      in   10       current y (0=top .. 479)
//  score       in   SCORE_W  binary score, sampled at frame start
//  blank_lz    in   1        1 = suppress leading zeros (units digit always drawn)
//  draw_score  out  1        pixel enable for the current hcount/vcount
//  overflow    out  1        latched score exceeded 10**DIGITS-1 (display saturates to all 9s)
//  busy        out  1        BCD conversion in progress
// BEHAVIOUR
//  Reset: all state cleared; draw_score=0, overflow=0, busy=0, displayed BCD=0, FSM=IDLE.
//  Frame start (FS) = pixpulse && hcount==0 && vcount==0.
//  FSM IDLE: on FS latch score into the shift register, clear the BCD accumulator,
//    set cnt=SCORE_W, go to CONV; busy=1 from the next clk.
//  FSM CONV: one iteration per clk (not gated by pixpulse).
//    Each iteration: every BCD nibble >=5 gets +3, then {bcd,shift} shifts left 1 bit; cnt decrements.
//    After SCORE_W iterations go to LOAD.
//  FSM LOAD (1 clk): write the display register, then go to IDLE; busy=0.
//    The display register holds {DIGITS nibbles}; the BCD accumulator has ceil((SCORE_W+3)/3) nibbles.
//    If the latched value > 10**DIGITS-1: display all 9s and overflow=1; else display the low DIGITS nibbles and overflow=0.
//  Conversion latency: FS to display update = SCORE_W+2 clks. This is < 1 line, so with YLOC>=1 there is no tearing.
//  score changes at any time other than FS have no effect until the next FS.
//  An FS arriving in CONV/LOAD is ignored (cannot occur at legal timing).
//  Rendering (registered): on each clk with pixpulse=1, draw_score <= f(hcount,vcount) for the values presented that cycle.
//    draw_score holds between pixpulses. Latency: 1 clk after the pixpulse cycle.
//  Region: XLOC <= hcount < XLOC+DIGITS*(8<<SCALE_LOG2) and YLOC <= vcount < YLOC+(8<<SCALE_LOG2).
//    Outside the region, draw_score <= 0.
//  Inside the region:
//    col = (hcount-XLOC)>>SCALE_LOG2; d = col>>3 (0 = most significant); bit = 7-(col&7).
//    row = (vcount-YLOC)>>SCALE_LOG2 (row 0 = top).
//    draw_score <= glyph[digit_d][row][bit].
//  Leading-zero blanking: with blank_lz=1, digit d is blank if it and all digits left of it are 0, for d < DIGITS-1.
//    blank_lz is sampled per pixel, not latched.
//  Glyph ROM: 10 glyphs x 8 rows x 8 bits, bit7 = leftmost pixel, standard team 8x8 numeral font.
//    ROM read is combinational from the registered display digit.
//  Reset asserted mid-conversion: abort to IDLE immediately. Displayed value returns to 0; the next FS restarts conversion.
// TESTING
//  1. DIGITS=3,SCORE_W=8: score=123, run 1 frame -> busy high 9 clks after FS; overflow=0.
//     Row scan at YLOC..YLOC+7 matches golden glyphs 1,2,3 in cells 0,1,2.
//  2. DIGITS=2,SCORE_W=8: score=255 -> overflow=1, both cells render '9'.
//     Then score=42 next frame -> overflow=0, cells render '4','2'.
//  3. score=7, blank_lz=1 -> draw_score=0 across cells 0,1; cell 2 = '7'.
//     blank_lz=0 -> cells render '0','0','7'. score=0,blank_lz=1 -> only units '0' drawn.
//  4. SCALE_LOG2=1, score=8: each glyph bit covers 2x2 pixels.
//     Region is 48x16; pixels at hcount=XLOC+48 and vcount=YLOC+16 are 0.
//  5. Change score 100->200 mid-frame (vcount=YLOC+3) -> rest of frame shows 100; next frame shows 200.
//  6. Assert rst_n=0 during CONV (3 clks after FS) -> busy=0, draw_score=0, display=0.
//     Release; next FS converts normally.

Source files
------------

// File: rtl/score_display_n.sv
// score_display_n: N-digit decimal score renderer for the 640x480 VGA path.
// A binary score is latched at frame start, converted to BCD by an iterative
// double-dabble FSM, and drawn from an 8x8 glyph ROM with integer scaling and
// optional leading-zero blanking. draw_score is a registered pixel enable.
module score_display_n #(
  parameter int unsigned XLOC       = 40,
  parameter int unsigned YLOC       = 40,
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned SCALE_LOG2 = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pixpulse,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic [SCORE_W-1:0] score,
  input  logic               blank_lz,
  output logic               draw_score,
  output logic               overflow,
  output logic               busy
);

  localparam int unsigned CELL   = 8 << SCALE_LOG2;
  localparam int unsigned WIDTH  = DIGITS * CELL;
  localparam int unsigned BCD_N  = (SCORE_W + 5) / 3;
  localparam int unsigned ACC_N  = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int unsigned ACC_W  = 4 * ACC_N;
  localparam int unsigned DISP_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(SCORE_W + 1);

  localparam logic [10:0] X_LO = 11'(XLOC);
  localparam logic [10:0] X_HI = 11'(XLOC + WIDTH);
  localparam logic [10:0] Y_LO = 11'(YLOC);
  localparam logic [10:0] Y_HI = 11'(YLOC + CELL);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  state_t              state_q, state_d;
  logic [SCORE_W-1:0]  sh_q, sh_d;
  logic [ACC_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic                draw_q, draw_d;

  logic                        fs;
  logic [ACC_W-1:0]            bcd_adj;
  logic [ACC_W+SCORE_W-1:0]    shifted;
  logic                        hi_nz;

  logic [10:0] hoff, voff, col, row_f;
  logic [2:0]  dsel, bsel, rsel;
  logic        in_reg;
  logic [3:0]  nib;
  logic        lead_blank;
  logic        run_zero;
  logic [7:0]  grow;
  logic        pix;
  logic        unused_bits;

  // 8x8 numeral font, row 0 at the top, bit 7 = leftmost pixel
  function automatic logic [7:0] glyph_row(input logic [3:0] g, input logic [2:0] r);
    logic [63:0] rows;
    case (g)
      4'd0:    rows = 64'h3C666E7666663C00;
      4'd1:    rows = 64'h183818181818_7E00;
      4'd2:    rows = 64'h3C66060C30607E00;
      4'd3:    rows = 64'h3C66061C06663C00;
      4'd4:    rows = 64'h0C1C3C6C7E0C0C00;
      4'd5:    rows = 64'h7E607C0606663C00;
      4'd6:    rows = 64'h3C607C6666663C00;
      4'd7:    rows = 64'h7E060C1830303000;
      4'd8:    rows = 64'h3C66663C66663C00;
      4'd9:    rows = 64'h3C66663E060C3800;
      default: rows = '0;
    endcase
    return rows[{3'd7 - r, 3'b000} +: 8];
  endfunction

  assign fs = pixpulse && (hcount == '0) && (vcount == '0);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      draw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      draw_q  <= draw_d;
    end
  end

  // Double-dabble add-3 correction on every nibble >= 5
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < ACC_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, sh_q} << 1;
  end

  // Any nonzero nibble above the displayed digits means the value exceeds 10**DIGITS-1
  always_comb begin
    hi_nz = 1'b0;
    for (int unsigned i = DIGITS; i < ACC_N; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) hi_nz = 1'b1;
    end
  end

  // Conversion FSM: IDLE latches on frame start, CONV shifts SCORE_W times, LOAD publishes
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (fs) begin
          sh_d    = score;
          bcd_d   = '0;
          cnt_d   = CNT_W'(SCORE_W);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = shifted[ACC_W+SCORE_W-1:SCORE_W];
        sh_d  = shifted[SCORE_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        ovf_d   = hi_nz;
        disp_d  = hi_nz ? {DIGITS{4'd9}} : bcd_q[DISP_W-1:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel lookup: region test, cell/glyph coordinates, digit select and blanking
  always_comb begin
    hoff   = {1'b0, hcount} - X_LO;
    voff   = {1'b0, vcount} - Y_LO;
    col    = hoff >> SCALE_LOG2;
    row_f  = voff >> SCALE_LOG2;
    dsel   = col[5:3];
    bsel   = 3'd7 - col[2:0];
    rsel   = row_f[2:0];
    in_reg = ({1'b0, hcount} >= X_LO) && ({1'b0, hcount} < X_HI) &&
             ({1'b0, vcount} >= Y_LO) && ({1'b0, vcount} < Y_HI);
    nib        = '0;
    lead_blank = 1'b0;
    run_zero   = 1'b1;
    // digit 0 is the most significant; run_zero tracks "this and all left of it are 0"
    for (int unsigned i = 0; i < DIGITS; i++) begin
      run_zero = run_zero && (disp_q[4*(DIGITS-1-i) +: 4] == 4'd0);
      if (dsel == 3'(i)) begin
        nib        = disp_q[4*(DIGITS-1-i) +: 4];
        lead_blank = run_zero && (i < DIGITS - 1);
      end
    end
    grow = glyph_row(nib, rsel);
    pix  = in_reg && !(blank_lz && lead_blank) && grow[bsel];
  end

  // Registered pixel enable, updated only on pixel strobes
  always_comb begin
    draw_d = draw_q;
    if (pixpulse) draw_d = pix;
  end

  assign unused_bits = ^{col[10:6], row_f[10:3]};

  assign busy       = (state_q != S_IDLE);
  assign overflow   = ovf_q;
  assign draw_score = draw_q;

endmodule

// File: tb/tb_score_display_n.sv
// tb_score_display_n: randomized and directed checks of score_display_n
// against an arithmetic reference model (decimal digits via / and %).
module tb_score_display_n;

  localparam int XLOC       = 40;
  localparam int YLOC       = 40;
  localparam int DIGITS     = 3;
  localparam int SCORE_W    = 10;
  localparam int SCALE_LOG2 = 1;
  localparam int CELL       = 8 << SCALE_LOG2;
  localparam int MAXV       = 999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pixpulse = 1'b0;
  logic [9:0]  hcount = 10'd5;
  logic [9:0]  vcount = 10'd5;
  logic [SCORE_W-1:0] score = '0;
  logic        blank_lz = 1'b0;
  logic        draw_score, overflow, busy;

  score_display_n #(
    .XLOC(XLOC), .YLOC(YLOC), .DIGITS(DIGITS), .SCORE_W(SCORE_W), .SCALE_LOG2(SCALE_LOG2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .score(score), .blank_lz(blank_lz), .draw_score(draw_score), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // golden 8x8 numerals, row 0 in the top byte, bit 7 leftmost
  logic [63:0] font [10] = '{
    64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00,
    64'h3C66061C06663C00, 64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00,
    64'h3C607C6666663C00, 64'h7E060C1830303000, 64'h3C66663C66663C00,
    64'h3C66663E060C3800 };

  function automatic logic pix_model(input int h, input int v, input int disp, input logic blz);
    int col, row, d, b, p, dig;
    logic [63:0] g;
    if (h < XLOC || h >= XLOC + DIGITS*CELL || v < YLOC || v >= YLOC + CELL) return 1'b0;
    col = (h - XLOC) >> SCALE_LOG2;
    row = (v - YLOC) >> SCALE_LOG2;
    d   = col / 8;
    b   = 7 - (col % 8);
    p   = 10 ** (DIGITS - 1 - d);
    dig = (disp / p) % 10;
    if (blz && d < DIGITS - 1 && disp < p) return 1'b0;
    g = font[dig];
    return g[(7 - row)*8 + b];
  endfunction

  // reference model: latency counter, saturating display value, registered pixel
  int   m_left = 0;
  int   m_lat  = 0;
  int   m_disp = 0;
  logic m_ovf  = 1'b0;
  logic m_draw = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_disp <= 0;
      m_ovf  <= 1'b0;
      m_draw <= 1'b0;
    end else begin
      if (pixpulse) m_draw <= pix_model(int'(hcount), int'(vcount), m_disp, blank_lz);
      if (m_left == 0) begin
        if (pixpulse && hcount == 10'd0 && vcount == 10'd0) begin
          m_left <= SCORE_W + 1;
          m_lat  <= int'(score);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_disp <= (m_lat > MAXV) ? MAXV : m_lat;
          m_ovf  <= (m_lat > MAXV);
        end
      end
    end
  end

  int    checks = 0;
  int    failures = 0;
  bit    lit_valid = 1'b0;
  int    lit_sel = 0;
  logic  lit_exp = 1'b0;
  string lit_name = "";
  logic  got, mv;

  // single compare process: model vs DUT every cycle, plus literal pins when requested
  always @(negedge clk) begin
    checks++;
    if (draw_score !== m_draw) begin
      failures++;
      $display("FAIL draw_score t=%0t h=%0d v=%0d dut=%b expected=%b", $time, hcount, vcount, draw_score, m_draw);
    end
    checks++;
    if (busy !== (m_left > 0)) begin
      failures++;
      $display("FAIL busy t=%0t dut=%b expected=%b", $time, busy, (m_left > 0));
    end
    checks++;
    if (overflow !== m_ovf) begin
      failures++;
      $display("FAIL overflow t=%0t dut=%b expected=%b", $time, overflow, m_ovf);
    end
    if (lit_valid) begin
      got = (lit_sel == 0) ? draw_score : (lit_sel == 1) ? overflow : busy;
      mv  = (lit_sel == 0) ? m_draw : (lit_sel == 1) ? m_ovf : (m_left > 0);
      checks++;
      if (got !== lit_exp) begin
        failures++;
        $display("FAIL lit_%s t=%0t dut=%b expected=%b", lit_name, $time, got, lit_exp);
      end
      checks++;
      if (mv !== lit_exp) begin
        failures++;
        $display("FAIL model_%s t=%0t model=%b expected=%b", lit_name, $time, mv, lit_exp);
      end
    end
  end

  task automatic lit(input int sel, input logic exp, input string name);
    @(posedge clk); #1;
    lit_sel = sel; lit_exp = exp; lit_name = name; lit_valid = 1'b1;
    @(negedge clk); #1;
    lit_valid = 1'b0;
  endtask

  task automatic pix(input int h, input int v);
    @(negedge clk);
    hcount = 10'(h); vcount = 10'(v); pixpulse = 1'b1;
    @(negedge clk);
    pixpulse = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic frame(input int s, input logic blz);
    score = 10'(s); blank_lz = blz;
    pix(0, 0);
    repeat (12) @(negedge clk);
  endtask

  task automatic scan_rows(input int v0, input int v1);
    for (int v = v0; v <= v1; v++)
      for (int h = XLOC - 1; h <= XLOC + DIGITS*CELL; h++) pix(h, v);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    lit(0, 1'b0, "reset_draw");
    lit(1, 1'b0, "reset_ovf");
    lit(2, 1'b0, "reset_busy");
    @(negedge clk); rst_n = 1'b1;

    // 123: busy window, no overflow, glyphs 1 2 3
    score = 10'd123; blank_lz = 1'b0;
    pix(0, 0);
    lit(2, 1'b1, "busy_after_fs");
    repeat (12) @(negedge clk);
    lit(2, 1'b0, "busy_done");
    lit(1, 1'b0, "ovf_123");
    scan_rows(YLOC - 1, YLOC + CELL);
    pix(XLOC + 6, YLOC);       lit(0, 1'b1, "glyph1_r0");
    pix(XLOC, YLOC);           lit(0, 1'b0, "glyph1_r0_c0");
    pix(XLOC + 38, YLOC + 6);  lit(0, 1'b1, "glyph3_r3");

    // saturation, then recovery
    frame(1000, 1'b0);
    lit(1, 1'b1, "ovf_1000");
    scan_rows(YLOC, YLOC + CELL - 1);
    frame(42, 1'b0);
    lit(1, 1'b0, "ovf_42");
    scan_rows(YLOC, YLOC + CELL - 1);

    // leading-zero blanking
    frame(7, 1'b1);
    scan_rows(YLOC, YLOC + CELL - 1);
    pix(XLOC + 2, YLOC + 2);   lit(0, 1'b0, "lz_blanked");
    blank_lz = 1'b0;
    pix(XLOC + 2, YLOC + 2);   lit(0, 1'b1, "lz_shown");
    scan_rows(YLOC, YLOC + CELL - 1);
    frame(0, 1'b1);
    scan_rows(YLOC, YLOC + CELL - 1);

    // 2x2 scaling and region edges
    frame(8, 1'b0);
    pix(XLOC + 36, YLOC + 1);  lit(0, 1'b1, "scale_a");
    pix(XLOC + 37, YLOC + 1);  lit(0, 1'b1, "scale_b");
    pix(XLOC + 48, YLOC + 1);  lit(0, 1'b0, "right_edge");
    pix(XLOC + 36, YLOC + 16); lit(0, 1'b0, "bottom_edge");
    scan_rows(YLOC - 1, YLOC + CELL);

    // score changes mid-frame are not seen until the next frame start
    frame(100, 1'b0);
    scan_rows(YLOC - 1, YLOC + 3);
    score = 10'd200;
    scan_rows(YLOC + 4, YLOC + CELL);
    pix(XLOC + 6, YLOC + 10);  lit(0, 1'b1, "midframe_old");
    frame(200, 1'b0);
    pix(XLOC + 6, YLOC + 10);  lit(0, 1'b0, "nextframe_new");

    // reset during conversion clears display and aborts
    frame(400, 1'b0);
    pix(XLOC + 4, YLOC + 12);  lit(0, 1'b0, "pre_reset_4");
    score = 10'd555;
    pix(0, 0);
    rst_n = 1'b0;
    lit(2, 1'b0, "busy_in_reset");
    lit(0, 1'b0, "draw_in_reset");
    @(negedge clk); rst_n = 1'b1;
    pix(XLOC + 4, YLOC + 12);  lit(0, 1'b1, "display_zero");
    frame(321, 1'b0);
    scan_rows(YLOC, YLOC + CELL - 1);

    // randomized frames and pixels, including frame starts during conversion
    for (int f = 0; f < 20; f++) begin
      score = 10'($urandom_range(0, 1023));
      blank_lz = 1'($urandom_range(0, 1));
      pix(0, 0);
      if ($urandom_range(0, 3) == 0) begin
        score = 10'($urandom_range(0, 1023));
        pix(0, 0);
      end
      for (int p = 0; p < 60; p++) begin
        if ($urandom_range(0, 4) == 0) score = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
        pix(XLOC - 4 + int'($urandom_range(0, 56)), YLOC - 4 + int'($urandom_range(0, 24)));
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
